// File: rtl/uart_mmio_arbiter_if.sv
// Uart_ift: MMIO request/response bundle between one requester and the UART slave.
// Master drives the request fields; Slave returns read data and completion pulses.
interface Uart_ift;
    logic [63:0] waddr_mem;
    logic [63:0] raddr_mem;
    logic [63:0] wdata_mem;
    logic [7:0]  wmask_mem;
    logic        wen_mem;
    logic        ren_mem;
    logic [63:0] rdata_mem;
    logic        rvalid_mem;
    logic        wvalid_mem;

    modport Master (
        output waddr_mem, raddr_mem, wdata_mem, wmask_mem, wen_mem, ren_mem,
        input  rdata_mem, rvalid_mem, wvalid_mem
    );

    modport Slave (
        input  waddr_mem, raddr_mem, wdata_mem, wmask_mem, wen_mem, ren_mem,
        output rdata_mem, rvalid_mem, wvalid_mem
    );
endinterface

// File: rtl/uart_mmio_arbiter.sv
// Round-robin arbiter sharing one UART MMIO slave between core (m0) and debug/DMA (m1).
// Optional watchdog completion enabled by defining UART_ARB_TIMEOUT_EN.
module uart_mmio_arbiter #(
    parameter int unsigned TIMEOUT       = 256,
    parameter logic [63:0] TIMEOUT_RDATA = 64'hDEAD_BEEF_DEAD_BEEF
) (
    input  logic    clk,
    input  logic    rstn,
    Uart_ift.Slave  m0,
    Uart_ift.Slave  m1,
    Uart_ift.Master uart
`ifdef UART_ARB_TIMEOUT_EN
    ,
    output logic    timeout_o
`endif
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_prio;
    logic        r_gnt_id;
    logic        r_ren;
    logic        r_wen;
    logic [63:0] r_raddr;
    logic [63:0] r_waddr;
    logic [63:0] r_wdata;
    logic [7:0]  r_wmask;

    logic        w_req0;
    logic        w_req1;
    logic        w_win;
    logic        w_win_wr;
    logic        w_grant;
    logic        w_to;
    logic        w_done_rd;
    logic        w_done_wr;
    logic        w_done;
    logic [63:0] w_rdata;

    assign w_req0   = m0.ren_mem | m0.wen_mem;
    assign w_req1   = m1.ren_mem | m1.wen_mem;
    assign w_win    = (w_req0 & w_req1) ? r_prio : w_req1;
    // A requester raising both enables gets its write serviced first.
    assign w_win_wr = w_win ? m1.wen_mem : m0.wen_mem;
    assign w_grant  = (r_state == S_IDLE) & (w_req0 | w_req1);

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

    logic [CNT_W-1:0] r_cnt;
    logic             w_expired;

    assign w_expired = (r_state != S_IDLE) && (r_cnt == CNT_W'(TIMEOUT - 1));
    // A real downstream valid in the expiry cycle takes precedence over the watchdog.
    assign w_to      = w_expired & ~(((r_state == S_RD) & uart.rvalid_mem) |
                                     ((r_state == S_WR) & uart.wvalid_mem));
    assign timeout_o = w_to;

    // Watchdog cycle counter: cleared on grant, counts while a transaction is open.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (w_grant) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (r_state != S_IDLE) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end
`else
    logic w_unused_cfg;

    assign w_to         = 1'b0;
    assign w_unused_cfg = (TIMEOUT < 32'd2);
`endif

    assign w_done_rd = (r_state == S_RD) & (uart.rvalid_mem | w_to);
    assign w_done_wr = (r_state == S_WR) & (uart.wvalid_mem | w_to);
    assign w_done    = w_done_rd | w_done_wr;
    assign w_rdata   = w_to ? TIMEOUT_RDATA : uart.rdata_mem;

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: grant from IDLE, return on the completion matching the open op.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_state_nxt = w_win_wr ? S_WR : S_RD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RD, S_WR: begin
                if (w_done) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Downstream request registers, grant id and round-robin pointer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_prio   <= 1'b0;
            r_gnt_id <= 1'b0;
            r_ren    <= 1'b0;
            r_wen    <= 1'b0;
            r_raddr  <= 64'd0;
            r_waddr  <= 64'd0;
            r_wdata  <= 64'd0;
            r_wmask  <= 8'd0;
        end else if (w_grant) begin
            r_gnt_id <= w_win;
            if (w_win_wr) begin
                r_wen   <= 1'b1;
                r_waddr <= w_win ? m1.waddr_mem : m0.waddr_mem;
                r_wdata <= w_win ? m1.wdata_mem : m0.wdata_mem;
                r_wmask <= w_win ? m1.wmask_mem : m0.wmask_mem;
            end else begin
                r_ren   <= 1'b1;
                r_raddr <= w_win ? m1.raddr_mem : m0.raddr_mem;
            end
        end else if (w_done) begin
            r_ren  <= 1'b0;
            r_wen  <= 1'b0;
            r_prio <= ~r_gnt_id;
        end else begin
            r_ren <= r_ren;
            r_wen <= r_wen;
        end
    end

    assign uart.ren_mem   = r_ren;
    assign uart.wen_mem   = r_wen;
    assign uart.raddr_mem = r_raddr;
    assign uart.waddr_mem = r_waddr;
    assign uart.wdata_mem = r_wdata;
    assign uart.wmask_mem = r_wmask;

    // Completion steering: only the granted requester sees rdata and valid pulses.
    always_comb begin
        m0.rdata_mem  = 64'd0;
        m0.rvalid_mem = 1'b0;
        m0.wvalid_mem = 1'b0;
        m1.rdata_mem  = 64'd0;
        m1.rvalid_mem = 1'b0;
        m1.wvalid_mem = 1'b0;
        if (r_gnt_id) begin
            m1.rdata_mem  = w_rdata;
            m1.rvalid_mem = w_done_rd;
            m1.wvalid_mem = w_done_wr;
        end else begin
            m0.rdata_mem  = w_rdata;
            m0.rvalid_mem = w_done_rd;
            m0.wvalid_mem = w_done_wr;
        end
    end
endmodule

// File: tb/tb_uart_mmio_arbiter.sv
// Directed self-checking bench for uart_mmio_arbiter (timeout scenarios need UART_ARB_TIMEOUT_EN).
module tb_uart_mmio_arbiter;
    logic clk;
    logic rstn;
    int   n_pass;
    int   n_total;
    int   ren_cycles;

    Uart_ift m0_if ();
    Uart_ift m1_if ();
    Uart_ift up_if ();

`ifdef UART_ARB_TIMEOUT_EN
    logic timeout_o;
`endif

    uart_mmio_arbiter #(
        .TIMEOUT       (8),
        .TIMEOUT_RDATA (64'hDEAD_BEEF_DEAD_BEEF)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .m0        (m0_if),
        .m1        (m1_if),
        .uart      (up_if)
`ifdef UART_ARB_TIMEOUT_EN
        ,
        .timeout_o (timeout_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        m0_if.ren_mem = 1'b0; m0_if.wen_mem = 1'b0; m0_if.raddr_mem = 64'd0;
        m0_if.waddr_mem = 64'd0; m0_if.wdata_mem = 64'd0; m0_if.wmask_mem = 8'd0;
        m1_if.ren_mem = 1'b0; m1_if.wen_mem = 1'b0; m1_if.raddr_mem = 64'd0;
        m1_if.waddr_mem = 64'd0; m1_if.wdata_mem = 64'd0; m1_if.wmask_mem = 8'd0;
        up_if.rdata_mem = 64'd0; up_if.rvalid_mem = 1'b0; up_if.wvalid_mem = 1'b0;
    endtask

    task automatic do_reset;
        rstn = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #2;
        n_total++; if (up_if.ren_mem !== 1'b0) $display("FAIL rst_uart_ren got=%0h exp=0", up_if.ren_mem); else n_pass++;
        n_total++; if (up_if.wen_mem !== 1'b0) $display("FAIL rst_uart_wen got=%0h exp=0", up_if.wen_mem); else n_pass++;
        n_total++; if ({up_if.raddr_mem, up_if.waddr_mem, up_if.wdata_mem} !== 192'd0) $display("FAIL rst_uart_fields got=nonzero exp=0"); else n_pass++;
        n_total++; if (up_if.wmask_mem !== 8'd0) $display("FAIL rst_uart_wmask got=%0h exp=0", up_if.wmask_mem); else n_pass++;
        n_total++; if ({m0_if.rvalid_mem, m0_if.wvalid_mem, m1_if.rvalid_mem, m1_if.wvalid_mem} !== 4'd0)
            $display("FAIL rst_valids got=%b exp=0000", {m0_if.rvalid_mem, m0_if.wvalid_mem, m1_if.rvalid_mem, m1_if.wvalid_mem}); else n_pass++;
        n_total++; if ({m0_if.rdata_mem, m1_if.rdata_mem} !== 128'd0) $display("FAIL rst_rdata got=nonzero exp=0"); else n_pass++;
`ifdef UART_ARB_TIMEOUT_EN
        n_total++; if (timeout_o !== 1'b0) $display("FAIL rst_timeout got=%0h exp=0", timeout_o); else n_pass++;
`endif
        @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic test_single_read;
        ren_cycles = 0;
        m0_if.raddr_mem = 64'h0000_0000_1000_0000;
        m0_if.ren_mem   = 1'b1;
        tick();
        if (up_if.ren_mem === 1'b1) ren_cycles++;
        n_total++; if (up_if.raddr_mem !== 64'h1000_0000) $display("FAIL rd_raddr got=%0h exp=10000000", up_if.raddr_mem); else n_pass++;
        n_total++; if (m0_if.rvalid_mem !== 1'b0) $display("FAIL rd_early_rvalid got=%0h exp=0", m0_if.rvalid_mem); else n_pass++;
        tick();
        if (up_if.ren_mem === 1'b1) ren_cycles++;
        tick();
        up_if.rvalid_mem = 1'b1;
        up_if.rdata_mem  = 64'h41;
        #1;
        if (up_if.ren_mem === 1'b1) ren_cycles++;
        n_total++; if (m0_if.rvalid_mem !== 1'b1) $display("FAIL rd_m0_rvalid got=%0h exp=1", m0_if.rvalid_mem); else n_pass++;
        n_total++; if (m0_if.rdata_mem !== 64'h41) $display("FAIL rd_m0_rdata got=%0h exp=41", m0_if.rdata_mem); else n_pass++;
        n_total++; if ({m1_if.rvalid_mem, m1_if.wvalid_mem} !== 2'b00) $display("FAIL rd_m1_valid got=%b exp=00", {m1_if.rvalid_mem, m1_if.wvalid_mem}); else n_pass++;
        n_total++; if (m1_if.rdata_mem !== 64'd0) $display("FAIL rd_m1_rdata got=%0h exp=0", m1_if.rdata_mem); else n_pass++;
        tick();
        up_if.rvalid_mem = 1'b0;
        up_if.rdata_mem  = 64'd0;
        m0_if.ren_mem    = 1'b0;
        #1;
        if (up_if.ren_mem === 1'b1) ren_cycles++;
        n_total++; if (ren_cycles !== 3) $display("FAIL rd_ren_cycles got=%0d exp=3", ren_cycles); else n_pass++;
    endtask

    task automatic test_contention;
        logic        exp_id [5];
        logic [63:0] exp_d  [5];
        logic [63:0] exp_a  [5];
        logic        got_v;
        logic        other_v;
        exp_id = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        exp_d  = '{64'h11, 64'h22, 64'h33, 64'h44, 64'h55};
        exp_a  = '{64'h100, 64'h200, 64'h300, 64'h400, 64'h500};
        m0_if.waddr_mem = 64'h100; m0_if.wdata_mem = 64'h11; m0_if.wmask_mem = 8'h01; m0_if.wen_mem = 1'b1;
        m1_if.waddr_mem = 64'h200; m1_if.wdata_mem = 64'h22; m1_if.wmask_mem = 8'h01; m1_if.wen_mem = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_total++; if (up_if.wen_mem !== 1'b1) $display("FAIL cont_wen_%0d got=%0h exp=1", k, up_if.wen_mem); else n_pass++;
            n_total++; if (up_if.wdata_mem !== exp_d[k]) $display("FAIL cont_wdata_%0d got=%0h exp=%0h", k, up_if.wdata_mem, exp_d[k]); else n_pass++;
            n_total++; if (up_if.waddr_mem !== exp_a[k]) $display("FAIL cont_waddr_%0d got=%0h exp=%0h", k, up_if.waddr_mem, exp_a[k]); else n_pass++;
            n_total++; if (up_if.wmask_mem !== 8'h01) $display("FAIL cont_wmask_%0d got=%0h exp=01", k, up_if.wmask_mem); else n_pass++;
            up_if.wvalid_mem = 1'b1;
            #1;
            got_v   = exp_id[k] ? m1_if.wvalid_mem : m0_if.wvalid_mem;
            other_v = exp_id[k] ? m0_if.wvalid_mem : m1_if.wvalid_mem;
            n_total++; if (got_v !== 1'b1) $display("FAIL cont_winner_wvalid_%0d got=%0h exp=1", k, got_v); else n_pass++;
            n_total++; if (other_v !== 1'b0) $display("FAIL cont_loser_wvalid_%0d got=%0h exp=0", k, other_v); else n_pass++;
            tick();
            up_if.wvalid_mem = 1'b0;
            if (exp_id[k]) m1_if.wen_mem = 1'b0; else m0_if.wen_mem = 1'b0;
            #1;
            n_total++; if (up_if.wen_mem !== 1'b0) $display("FAIL cont_idle_gap_%0d got=%0h exp=0", k, up_if.wen_mem); else n_pass++;
            if (k == 1) begin
                m0_if.waddr_mem = 64'h300; m0_if.wdata_mem = 64'h33; m0_if.wen_mem = 1'b1;
            end
            if (k == 2) begin
                m0_if.waddr_mem = 64'h500; m0_if.wdata_mem = 64'h55; m0_if.wen_mem = 1'b1;
                m1_if.waddr_mem = 64'h400; m1_if.wdata_mem = 64'h44; m1_if.wen_mem = 1'b1;
            end
        end
    endtask

    task automatic test_held_fields;
        m0_if.waddr_mem = 64'hA0; m0_if.wdata_mem = 64'h5A; m0_if.wmask_mem = 8'h0F; m0_if.wen_mem = 1'b1;
        tick();
        m0_if.waddr_mem = 64'hB0; m0_if.wdata_mem = 64'hFF; m0_if.wmask_mem = 8'hFF;
        tick();
        n_total++; if (up_if.waddr_mem !== 64'hA0) $display("FAIL held_waddr got=%0h exp=a0", up_if.waddr_mem); else n_pass++;
        n_total++; if (up_if.wdata_mem !== 64'h5A) $display("FAIL held_wdata got=%0h exp=5a", up_if.wdata_mem); else n_pass++;
        n_total++; if (up_if.wmask_mem !== 8'h0F) $display("FAIL held_wmask got=%0h exp=0f", up_if.wmask_mem); else n_pass++;
        up_if.wvalid_mem = 1'b1;
        tick();
        up_if.wvalid_mem = 1'b0;
        m0_if.wen_mem    = 1'b0;
        tick();
    endtask

    task automatic test_spurious;
        m1_if.raddr_mem = 64'h2000;
        m1_if.ren_mem   = 1'b1;
        tick();
        up_if.wvalid_mem = 1'b1;
        #1;
        n_total++; if ({m0_if.wvalid_mem, m1_if.wvalid_mem, m1_if.rvalid_mem} !== 3'b000)
            $display("FAIL spur_forwarded got=%b exp=000", {m0_if.wvalid_mem, m1_if.wvalid_mem, m1_if.rvalid_mem}); else n_pass++;
        tick();
        up_if.wvalid_mem = 1'b0;
        #1;
        n_total++; if (up_if.ren_mem !== 1'b1) $display("FAIL spur_still_rd got=%0h exp=1", up_if.ren_mem); else n_pass++;
        up_if.rvalid_mem = 1'b1;
        up_if.rdata_mem  = 64'h77;
        #1;
        n_total++; if (m1_if.rvalid_mem !== 1'b1) $display("FAIL spur_m1_rvalid got=%0h exp=1", m1_if.rvalid_mem); else n_pass++;
        n_total++; if (m1_if.rdata_mem !== 64'h77) $display("FAIL spur_m1_rdata got=%0h exp=77", m1_if.rdata_mem); else n_pass++;
        n_total++; if (m0_if.rdata_mem !== 64'd0) $display("FAIL spur_m0_rdata got=%0h exp=0", m0_if.rdata_mem); else n_pass++;
        tick();
        up_if.rvalid_mem = 1'b0;
        up_if.rdata_mem  = 64'd0;
        m1_if.ren_mem    = 1'b0;
        tick();
        up_if.rvalid_mem = 1'b1;
        #1;
        n_total++; if ({m0_if.rvalid_mem, m1_if.rvalid_mem} !== 2'b00) $display("FAIL spur_idle_fwd got=%b exp=00", {m0_if.rvalid_mem, m1_if.rvalid_mem}); else n_pass++;
        tick();
        up_if.rvalid_mem = 1'b0;
        #1;
        n_total++; if ({up_if.ren_mem, up_if.wen_mem} !== 2'b00) $display("FAIL spur_idle_state got=%b exp=00", {up_if.ren_mem, up_if.wen_mem}); else n_pass++;
    endtask

    task automatic test_reset_mid_read;
        m0_if.raddr_mem = 64'h3000;
        m0_if.ren_mem   = 1'b1;
        tick();
        #2;
        rstn             = 1'b0;
        up_if.rvalid_mem = 1'b1;
        #1;
        n_total++; if (up_if.ren_mem !== 1'b0) $display("FAIL rstmid_ren got=%0h exp=0", up_if.ren_mem); else n_pass++;
        n_total++; if ({m0_if.rvalid_mem, m1_if.rvalid_mem} !== 2'b00) $display("FAIL rstmid_valid got=%b exp=00", {m0_if.rvalid_mem, m1_if.rvalid_mem}); else n_pass++;
        @(posedge clk);
        #2;
        rstn             = 1'b1;
        up_if.rvalid_mem = 1'b0;
        m0_if.ren_mem    = 1'b0;
        tick();
        n_total++; if ({up_if.ren_mem, up_if.wen_mem} !== 2'b00) $display("FAIL rstmid_idle got=%b exp=00", {up_if.ren_mem, up_if.wen_mem}); else n_pass++;
        m1_if.raddr_mem = 64'h6000;
        m1_if.ren_mem   = 1'b1;
        tick();
        n_total++; if (up_if.ren_mem !== 1'b1 || up_if.raddr_mem !== 64'h6000)
            $display("FAIL rstmid_regrant got=%0h/%0h exp=1/6000", up_if.ren_mem, up_if.raddr_mem); else n_pass++;
        up_if.rvalid_mem = 1'b1;
        #1;
        n_total++; if (m1_if.rvalid_mem !== 1'b1) $display("FAIL rstmid_m1_rvalid got=%0h exp=1", m1_if.rvalid_mem); else n_pass++;
        tick();
        up_if.rvalid_mem = 1'b0;
        m1_if.ren_mem    = 1'b0;
        tick();
    endtask

`ifdef UART_ARB_TIMEOUT_EN
    task automatic test_timeout;
        m1_if.raddr_mem = 64'h4000;
        m1_if.ren_mem   = 1'b1;
        for (int i = 1; i < 8; i++) begin
            tick();
            n_total++; if ({m1_if.rvalid_mem, timeout_o} !== 2'b00) $display("FAIL to_early_%0d got=%b exp=00", i, {m1_if.rvalid_mem, timeout_o}); else n_pass++;
        end
        tick();
        n_total++; if (m1_if.rvalid_mem !== 1'b1) $display("FAIL to_m1_rvalid got=%0h exp=1", m1_if.rvalid_mem); else n_pass++;
        n_total++; if (m1_if.rdata_mem !== 64'hDEAD_BEEF_DEAD_BEEF) $display("FAIL to_m1_rdata got=%0h exp=deadbeefdeadbeef", m1_if.rdata_mem); else n_pass++;
        n_total++; if (timeout_o !== 1'b1) $display("FAIL to_pulse got=%0h exp=1", timeout_o); else n_pass++;
        n_total++; if (m0_if.rvalid_mem !== 1'b0) $display("FAIL to_m0_rvalid got=%0h exp=0", m0_if.rvalid_mem); else n_pass++;
        tick();
        m1_if.ren_mem = 1'b0;
        n_total++; if ({timeout_o, up_if.ren_mem} !== 2'b00) $display("FAIL to_after got=%b exp=00", {timeout_o, up_if.ren_mem}); else n_pass++;
        m0_if.raddr_mem = 64'h5000;
        m0_if.ren_mem   = 1'b1;
        repeat (7) tick();
        tick();
        up_if.rvalid_mem = 1'b1;
        up_if.rdata_mem  = 64'h99;
        #1;
        n_total++; if (m0_if.rvalid_mem !== 1'b1 || m0_if.rdata_mem !== 64'h99)
            $display("FAIL to_race_data got=%0h/%0h exp=1/99", m0_if.rvalid_mem, m0_if.rdata_mem); else n_pass++;
        n_total++; if (timeout_o !== 1'b0) $display("FAIL to_race_pulse got=%0h exp=0", timeout_o); else n_pass++;
        tick();
        up_if.rvalid_mem = 1'b0;
        up_if.rdata_mem  = 64'd0;
        m0_if.ren_mem    = 1'b0;
        tick();
    endtask
`endif

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_single_read();
        do_reset();
        test_contention();
        test_held_fields();
        test_spurious();
        test_reset_mid_read();
`ifdef UART_ARB_TIMEOUT_EN
        do_reset();
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
